// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one i2c_com write master between two register-write ports.
// Define I2C_ARB_RR_EN for round-robin grant; default build is fixed priority (port 0).
module i2c_cmd_arbiter #(
  parameter logic [7:0] DEV_ADDR  = 8'h34,
  parameter int         CLK_DIV   = 1249,
  parameter int         MAX_RETRY = 3,
  parameter int         TIMEOUT   = 64
) (
  input  logic        clock_50m,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_done,
  output logic        req1_err,
  output logic        i2c_clk,
  output logic [23:0] i2c_data,
  output logic        i2c_start,
  input  logic        i2c_tr_end,
  input  logic        i2c_ack,
  output logic        busy
);

  localparam int CW = $clog2(CLK_DIV + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LAUNCH  = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          i2c_clk_q, i2c_clk_d;
  logic [2:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic [23:0]   data_q, data_d;
  logic          start_q, start_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] to_q, to_d;
  logic          res_q, res_d;
  logic          pulsed_q, pulsed_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          tr_s1_q, tr_s2_q;
  logic          ack_s1_q, ack_s2_q;
  logic          wrap, tick, pick;
`ifdef I2C_ARB_RR_EN
  logic          rr_last_q, rr_last_d;
`endif

  always_comb begin
    wrap      = cnt_q == CW'(CLK_DIV);
    tick      = wrap & i2c_clk_q;
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    i2c_clk_d = i2c_clk_q ^ wrap;
`ifdef I2C_ARB_RR_EN
    pick = (req0_valid & req1_valid) ? ~rr_last_q : (req1_valid & ~req0_valid);
`else
    pick = ~req0_valid;
`endif
  end

  // FSM steps only on the i2c_clk falling tick so i2c_com sees stable inputs at rise
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    start_d  = start_q;
    retry_d  = retry_q;
    to_d     = to_q;
    res_d    = res_q;
    pulsed_d = pulsed_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
`ifdef I2C_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    if (tick) begin
      case (state_q)
        IDLE: if (req0_valid | req1_valid) begin
          grant_d = pick;
          data_d  = {DEV_ADDR, pick ? req1_data : req0_data};
          retry_d = '0;
          state_d = LAUNCH;
`ifdef I2C_ARB_RR_EN
          rr_last_d = pick;
`endif
        end
        LAUNCH: begin
          start_d = 1'b1;
          to_d    = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (tr_s2_q) begin
            start_d = 1'b0;
            if (!ack_s2_q) begin
              res_d    = 1'b0;
              pulsed_d = 1'b0;
              state_d  = DONE;
            end else if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              state_d = RELEASE;
            end else begin
              res_d    = 1'b1;
              pulsed_d = 1'b0;
              state_d  = DONE;
            end
          end else if (to_q == TW'(TIMEOUT - 1)) begin
            start_d  = 1'b0;
            res_d    = 1'b1;
            pulsed_d = 1'b0;
            state_d  = DONE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        RELEASE: if (!tr_s2_q) state_d = LAUNCH;
        DONE: begin
          if (!pulsed_q) begin
            pulsed_d = 1'b1;
            done0_d  = ~grant_q;
            done1_d  = grant_q;
            err0_d   = ~grant_q & res_q;
            err1_d   = grant_q & res_q;
          end
          // wait for tr_end to clear so a stale level cannot end the next command
          if (!tr_s2_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      i2c_clk_q <= 1'b0;
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      data_q    <= 24'h0;
      start_q   <= 1'b0;
      retry_q   <= '0;
      to_q      <= '0;
      res_q     <= 1'b0;
      pulsed_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      tr_s1_q   <= 1'b0;
      tr_s2_q   <= 1'b0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
`ifdef I2C_ARB_RR_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      cnt_q     <= cnt_d;
      i2c_clk_q <= i2c_clk_d;
      state_q   <= state_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      start_q   <= start_d;
      retry_q   <= retry_d;
      to_q      <= to_d;
      res_q     <= res_d;
      pulsed_q  <= pulsed_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      tr_s1_q   <= i2c_tr_end;
      tr_s2_q   <= tr_s1_q;
      ack_s1_q  <= i2c_ack;
      ack_s2_q  <= ack_s1_q;
`ifdef I2C_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign req0_done = done0_q;
  assign req0_err  = err0_q;
  assign req1_done = done1_q;
  assign req1_err  = err1_q;
  assign i2c_clk   = i2c_clk_q;
  assign i2c_data  = data_q;
  assign i2c_start = start_q;
  assign busy      = state_q != IDLE;

endmodule
